tristate_inv_delay_ctl: RTL
===========================

Name: tristate_inv_delay_ctl

Overview:
- Registered control-code generator that directly drives the ctl/ctl_b inputs of the 128-tap tristate-inverter delay line used for SRAM BIST timing tuning.
- Converts a binary tap select into a one-hot ctl code and its one-cold ctl_b complement, and reports when the line has settled after a code change.
- Provides an autonomous sweep mode so BIST can step the delay across a programmable tap range, dwelling a set number of cycles per tap.

Parameters:
- CONTROL_WIDTH, 128, number of delay taps (width of ctl/ctl_b).
- SEL_WIDTH, 7, binary select width, equal to clog2(CONTROL_WIDTH).
- SETTLE_CYCLES, 4, cycles settled stays low after any code change (range 1..15).
- DWELL_WIDTH, 8, width of the sweep dwell count.

Ports:
- clk  input  1  block clock.
- rstb  input  1  asynchronous active-low reset.
- req_valid  input  1  manual select request.
- req_ready  output  1  manual request accepted when high with req_valid.
- req_sel  input  SEL_WIDTH  manual tap index.
- sweep_go  input  1  one-cycle pulse that starts a sweep.
- sweep_abort  input  1  stops an active sweep.
- sweep_start  input  SEL_WIDTH  first tap of the sweep.
- sweep_end  input  SEL_WIDTH  last tap of the sweep.
- sweep_dwell  input  DWELL_WIDTH  settled cycles spent per tap, minus 1.
- ctl  output  CONTROL_WIDTH  one-hot code to the delay line.
- ctl_b  output  CONTROL_WIDTH  bitwise complement of ctl.
- cur_sel  output  SEL_WIDTH  binary index of the hot bit.
- settled  output  1  code has been stable for at least SETTLE_CYCLES cycles.
- sweep_active  output  1  sweep in progress.
- sweep_done  output  1  one-cycle pulse when a sweep completes normally.

Behaviour:
- All outputs are registered.
- Invariants, every cycle including reset:
  - popcount(ctl) == 1.
  - ctl_b == ~ctl.
  - ctl == 1 << cur_sel.
- Reset (rstb low, asynchronous) forces:
  - cur_sel=0, ctl=1, ctl_b=~1.
  - settled=0, req_ready=0, sweep_active=0, sweep_done=0.
  - state=SETTLE, settle counter=0.
- States:
  - IDLE: req_ready=1, settled=1.
  - SETTLE: counts SETTLE_CYCLES cycles with settled=0.
  - DWELL: counts sweep_dwell+1 cycles with settled=1.
- The settle counter is 4 bits wide.
- IDLE transitions:
  - sweep_go has priority over req_valid. On sweep_go: cur_sel <= sweep_start, sweep_active <= 1, go to SETTLE. req_ready is still 1, but the request is not consumed (req_valid && req_ready counts as accepted only when sweep_go is low).
  - Manual request (req_valid && req_ready, sweep_go low, edge N): cur_sel/ctl/ctl_b update at edge N; settled and req_ready go 0 at edge N; go to SETTLE.
  - Re-selecting the current tap still takes the full settle.
- SETTLE: after SETTLE_CYCLES cycles, settled=1 at edge N+SETTLE_CYCLES. Next state is DWELL if sweep_active, else IDLE.
- DWELL, when the count expires:
  - If cur_sel == sweep_end: sweep_done=1 for one cycle, sweep_active=0, go to IDLE.
  - Else cur_sel <= cur_sel+1 modulo CONTROL_WIDTH (127 wraps to 0, so start > end sweeps through the wrap), settled=0, go to SETTLE.
- sweep_start == sweep_end: single tap, then done.
- sweep_abort:
  - In DWELL: IDLE on the next edge with the code unchanged; sweep_active=0; no sweep_done.
  - In SETTLE during a sweep: sweep_active cleared; the settle completes, then IDLE.
  - Ignored in IDLE.
- sweep_go outside IDLE is ignored. req_valid outside IDLE waits (req_ready=0).
- sweep_start, sweep_end and sweep_dwell are sampled live; they must be held stable while sweep_active.

Test Plan:
- Reset release: rstb low then high -> ctl=0x1, ctl_b=~0x1, settled rises exactly 4 cycles after the first edge, req_ready=1 in the same cycle.
- Manual select: req_sel=100 accepted -> ctl bit 100 only, ctl_b bit 100 low and all others high, cur_sel=100, settled low for exactly 4 cycles.
- Sweep start=5, end=8, dwell=2 -> taps 5,6,7,8 each show 4 unsettled + 3 settled cycles; sweep_done pulses once; sweep_active falls; final cur_sel=8.
- Wrap sweep start=126, end=1, dwell=0 -> tap sequence 126,127,0,1, then done.
- Abort in DWELL at tap 7 -> IDLE next cycle, cur_sel=7, no sweep_done. Abort in SETTLE -> settle finishes before req_ready=1.
- Simultaneous sweep_go and req_valid in IDLE -> sweep wins, request still pending and accepted after sweep_done. Async reset mid-sweep -> outputs reset immediately.
- Every test: check popcount(ctl)==1 and ctl_b==~ctl on every cycle.

Source files
------------

// File: rtl/tristate_inv_delay_ctl.sv
// Control-code generator for the tristate-inverter delay line: one-hot ctl/ctl_b
// from a binary tap select, settle tracking, and an autonomous tap sweep.
module tristate_inv_delay_ctl #(
    parameter int CONTROL_WIDTH = 128,
    parameter int SEL_WIDTH     = 7,
    parameter int SETTLE_CYCLES = 4,
    parameter int DWELL_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [SEL_WIDTH-1:0]     req_sel,
    input  logic                     sweep_go,
    input  logic                     sweep_abort,
    input  logic [SEL_WIDTH-1:0]     sweep_start,
    input  logic [SEL_WIDTH-1:0]     sweep_end,
    input  logic [DWELL_WIDTH-1:0]   sweep_dwell,
    output logic [CONTROL_WIDTH-1:0] ctl,
    output logic [CONTROL_WIDTH-1:0] ctl_b,
    output logic [SEL_WIDTH-1:0]     cur_sel,
    output logic                     settled,
    output logic                     sweep_active,
    output logic                     sweep_done
);

    localparam logic [3:0]               SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [SEL_WIDTH-1:0]     SEL_LAST    = SEL_WIDTH'(CONTROL_WIDTH - 1);
    localparam logic [CONTROL_WIDTH-1:0] CTL_ONE     = CONTROL_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DWELL
    } state_t;

    state_t                 state, state_nx;
    logic [3:0]             settle_cnt, settle_cnt_nx;
    logic [DWELL_WIDTH-1:0] dwell_cnt, dwell_cnt_nx;
    logic [SEL_WIDTH-1:0]   cur_sel_nx;
    logic                   settled_nx;
    logic                   req_ready_nx;
    logic                   sweep_active_nx;
    logic                   sweep_done_nx;
    logic [SEL_WIDTH-1:0]   sel_inc;

    // Tap increment wraps explicitly so non-power-of-two line lengths also work.
    assign sel_inc = (cur_sel == SEL_LAST) ? '0 : cur_sel + 1'b1;

    always_comb begin
        state_nx        = state;
        settle_cnt_nx   = settle_cnt;
        dwell_cnt_nx    = dwell_cnt;
        cur_sel_nx      = cur_sel;
        settled_nx      = settled;
        req_ready_nx    = req_ready;
        sweep_active_nx = sweep_active;
        sweep_done_nx   = 1'b0;

        case (state)
            IDLE: begin
                if (sweep_go) begin
                    cur_sel_nx      = sweep_start;
                    sweep_active_nx = 1'b1;
                    state_nx        = SETTLE;
                    settle_cnt_nx   = '0;
                    settled_nx      = 1'b0;
                    req_ready_nx    = 1'b0;
                end else if (req_valid && req_ready) begin
                    cur_sel_nx    = req_sel;
                    state_nx      = SETTLE;
                    settle_cnt_nx = '0;
                    settled_nx    = 1'b0;
                    req_ready_nx  = 1'b0;
                end
            end

            SETTLE: begin
                if (sweep_abort) begin
                    sweep_active_nx = 1'b0;
                end
                if (settle_cnt == SETTLE_LAST) begin
                    settled_nx = 1'b1;
                    // An abort landing on the final settle edge still drops back to IDLE.
                    if (sweep_active && !sweep_abort) begin
                        state_nx     = DWELL;
                        dwell_cnt_nx = '0;
                    end else begin
                        state_nx     = IDLE;
                        req_ready_nx = 1'b1;
                    end
                end else begin
                    settle_cnt_nx = settle_cnt + 1'b1;
                end
            end

            DWELL: begin
                if (sweep_abort) begin
                    sweep_active_nx = 1'b0;
                    state_nx        = IDLE;
                    req_ready_nx    = 1'b1;
                end else if (dwell_cnt == sweep_dwell) begin
                    if (cur_sel == sweep_end) begin
                        sweep_done_nx   = 1'b1;
                        sweep_active_nx = 1'b0;
                        state_nx        = IDLE;
                        req_ready_nx    = 1'b1;
                    end else begin
                        cur_sel_nx    = sel_inc;
                        settled_nx    = 1'b0;
                        settle_cnt_nx = '0;
                        state_nx      = SETTLE;
                    end
                end else begin
                    dwell_cnt_nx = dwell_cnt + 1'b1;
                end
            end

            default: begin
                state_nx      = SETTLE;
                settle_cnt_nx = '0;
                settled_nx    = 1'b0;
                req_ready_nx  = 1'b0;
            end
        endcase
    end

    // ctl/ctl_b are decoded from the next select so they change on the same edge as cur_sel.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state        <= SETTLE;
            settle_cnt   <= '0;
            dwell_cnt    <= '0;
            cur_sel      <= '0;
            ctl          <= CTL_ONE;
            ctl_b        <= ~CTL_ONE;
            settled      <= 1'b0;
            req_ready    <= 1'b0;
            sweep_active <= 1'b0;
            sweep_done   <= 1'b0;
        end else begin
            state        <= state_nx;
            settle_cnt   <= settle_cnt_nx;
            dwell_cnt    <= dwell_cnt_nx;
            cur_sel      <= cur_sel_nx;
            ctl          <= CTL_ONE << cur_sel_nx;
            ctl_b        <= ~(CTL_ONE << cur_sel_nx);
            settled      <= settled_nx;
            req_ready    <= req_ready_nx;
            sweep_active <= sweep_active_nx;
            sweep_done   <= sweep_done_nx;
        end
    end

endmodule
